if_fetch_buffer: RTL and testbench

Parametrised instruction fetch stage, replacing the single-entry fetch stage between the instruction RAM and the ID pipeline register. It handles the split `iram_addr_ok`/`iram_data_ok` handshake, keeps up to `MAX_OS` fetches in flight, and buffers returned instructions in a `DEPTH`-entry FIFO. A redirect from EX, or a flush from ID, squashes both buffered and in-flight fetches without stalling the RAM protocol.

---
 rtl/if_fetch_buffer.sv | 85 ++++++++
 tb/tb_if_fetch_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: instruction fetch stage with split RAM handshake, in-flight tracking and instruction FIFO
module if_fetch_buffer #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4,
  parameter int MAX_OS = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic            id_pipe_valid,
  input  logic            id_pipe_ready,
  input  logic            id_pipe_flush,
  output logic [XLEN-1:0] id_pipe_pc,
  output logic [XLEN-1:0] id_pipe_instruction,
  input  logic            ex_branch,
  input  logic [XLEN-1:0] ex_branch_pc,
  output logic            iram_req,
  output logic            iram_write,
  output logic [XLEN/8-1:0] iram_wstrb,
  output logic [XLEN-1:0] iram_wdata,
  output logic [XLEN-1:0] iram_addr,
  input  logic            iram_addr_ok,
  input  logic            iram_data_ok,
  input  logic [XLEN-1:0] iram_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OS + 1);
  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0] os_cnt, drop_cnt, live;
  logic [XLEN-1:0] q [MAX_OS];
  logic [XLEN-1:0] q_n [MAX_OS];
  logic [XLEN-1:0] f_pc [DEPTH];
  logic [XLEN-1:0] f_ins [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] fifo_cnt;
  logic flush, issue, rsp, push, pop;
  assign flush = ex_branch | id_pipe_flush;
  assign live = os_cnt - drop_cnt;
  assign iram_req = rst_b & ~flush & (os_cnt < OW'(MAX_OS))
                  & ((CW+1)'(fifo_cnt) + (CW+1)'(live) < (CW+1)'(DEPTH));
  assign issue = iram_req & iram_addr_ok;
  assign rsp = iram_data_ok & (os_cnt != '0);
  assign push = rsp & (drop_cnt == '0) & ~flush;
  assign pop = id_pipe_valid & id_pipe_ready & ~flush;
  assign id_pipe_valid = rst_b & (fifo_cnt != '0);
  assign id_pipe_pc = id_pipe_valid ? f_pc[rd] : '0;
  assign id_pipe_instruction = id_pipe_valid ? f_ins[rd] : '0;
  assign iram_addr = fetch_pc;
  assign iram_write = 1'b0;
  assign iram_wstrb = '0;
  assign iram_wdata = '0;
  // in-flight PC queue: shift out the oldest on a response, append the accepted address behind the survivors
  always_comb begin
    for (int i = 0; i < MAX_OS; i++)
      q_n[i] = (issue && OW'(i) == os_cnt - OW'(rsp)) ? fetch_pc : rsp ? q[(i + 1) % MAX_OS] : q[i];
  end
  // fetch pointer, outstanding/drop counters and FIFO occupancy; a flush empties the FIFO and marks every surviving request as dropped
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      fetch_pc <= RESET_PC;
      os_cnt <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      rd <= '0;
      wr <= '0;
    end else begin
      fetch_pc <= ex_branch ? ex_branch_pc : issue ? fetch_pc + XLEN'(4) : fetch_pc;
      os_cnt <= os_cnt + OW'(issue) - OW'(rsp);
      drop_cnt <= flush ? os_cnt - OW'(rsp) : drop_cnt - OW'(rsp && drop_cnt != '0);
      fifo_cnt <= flush ? '0 : fifo_cnt + CW'(push) - CW'(pop);
      rd <= flush ? wr : rd + AW'(pop);
      wr <= wr + AW'(push);
    end
  end
  // storage arrays carry no reset; validity is tracked by the counters alone
  always_ff @(posedge clk) begin
    q <= q_n;
    if (push) begin
      f_pc[wr] <= q[0];
      f_ins[wr] <= iram_rdata;
    end
  end
  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_b) !(iram_data_ok && os_cnt == '0));
endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb_if_fetch_buffer: randomized checks of if_fetch_buffer against a queue-based reference model
module tb_if_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int MAX_OS = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  typedef struct packed { logic [31:0] pc; logic drop; } fl_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } fe_t;
  typedef struct packed { logic [31:0] addr; int due; } rq_t;
  logic clk = 0, rst_b = 0;
  logic id_pipe_valid, id_pipe_ready = 0, id_pipe_flush = 0;
  logic [31:0] id_pipe_pc, id_pipe_instruction;
  logic ex_branch = 0;
  logic [31:0] ex_branch_pc = 0;
  logic iram_req, iram_write;
  logic [3:0] iram_wstrb;
  logic [31:0] iram_wdata, iram_addr;
  logic iram_addr_ok = 0, iram_data_ok = 0;
  logic [31:0] iram_rdata = 0;
  fl_t inflight[$];
  fe_t fifoq[$];
  rq_t pend[$];
  logic [31:0] got_pc[$];
  int got_cyc[$];
  logic [31:0] mpc = RESET_PC;
  int cyc = 0, total = 0, bad = 0, aprob = 100, lat_lo = 1, lat_hi = 1;
  if_fetch_buffer #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OS(MAX_OS)) dut (
    .clk(clk), .rst_b(rst_b), .id_pipe_valid(id_pipe_valid), .id_pipe_ready(id_pipe_ready),
    .id_pipe_flush(id_pipe_flush), .id_pipe_pc(id_pipe_pc), .id_pipe_instruction(id_pipe_instruction),
    .ex_branch(ex_branch), .ex_branch_pc(ex_branch_pc), .iram_req(iram_req), .iram_write(iram_write),
    .iram_wstrb(iram_wstrb), .iram_wdata(iram_wdata), .iram_addr(iram_addr), .iram_addr_ok(iram_addr_ok),
    .iram_data_ok(iram_data_ok), .iram_rdata(iram_rdata));
  always #5 clk = ~clk;
  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  // one clock: drive the RAM model, compare DUT outputs with the model, then advance the model at the edge
  task automatic step();
    int live;
    logic er, s_acc, s_rsp, s_pop, fl;
    fl_t e;
    @(negedge clk);
    iram_addr_ok = $urandom_range(99) < aprob;
    iram_data_ok = pend.size() > 0 && pend[0].due <= cyc;
    iram_rdata = iram_data_ok ? img(pend[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (inflight[i]) if (!inflight[i].drop) live++;
    er = rst_b && !(ex_branch || id_pipe_flush) && inflight.size() < MAX_OS && fifoq.size() + live < DEPTH;
    total++;
    if (iram_req !== er) begin bad++; $display("FAIL req cyc=%0d got=%b exp=%b", cyc, iram_req, er); end
    total++;
    if (id_pipe_valid !== (rst_b && fifoq.size() > 0)) begin
      bad++; $display("FAIL valid cyc=%0d got=%b exp=%0d", cyc, id_pipe_valid, fifoq.size());
    end
    if (rst_b && fifoq.size() > 0) begin
      total++;
      if (id_pipe_pc !== fifoq[0].pc || id_pipe_instruction !== fifoq[0].ins) begin
        bad++; $display("FAIL head cyc=%0d got=%h/%h exp=%h/%h", cyc, id_pipe_pc, id_pipe_instruction, fifoq[0].pc, fifoq[0].ins);
      end
    end
    if (er) begin
      total++;
      if (iram_addr !== mpc) begin bad++; $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, iram_addr, mpc); end
    end
    total++;
    if (dut.os_cnt > MAX_OS || dut.fifo_cnt > DEPTH) begin
      bad++; $display("FAIL bounds cyc=%0d os=%0d fifo=%0d max %0d/%0d", cyc, dut.os_cnt, dut.fifo_cnt, MAX_OS, DEPTH);
    end
    s_acc = iram_req & iram_addr_ok;
    s_rsp = iram_data_ok;
    s_pop = id_pipe_valid & id_pipe_ready;
    fl = ex_branch | id_pipe_flush;
    @(posedge clk);
    if (!rst_b) begin
      inflight.delete(); fifoq.delete(); pend.delete(); got_pc.delete(); got_cyc.delete();
      mpc = RESET_PC; cyc = 0;
    end else begin
      if (s_pop && !fl) begin got_pc.push_back(fifoq[0].pc); got_cyc.push_back(cyc); void'(fifoq.pop_front()); end
      if (s_rsp) begin
        e = inflight.pop_front();
        void'(pend.pop_front());
        if (!e.drop && !fl) fifoq.push_back('{e.pc, img(e.pc)});
      end
      if (fl) begin fifoq.delete(); foreach (inflight[i]) inflight[i].drop = 1'b1; end
      if (s_acc) begin
        inflight.push_back('{mpc, 1'b0});
        pend.push_back('{mpc, cyc + int'($urandom_range(lat_hi, lat_lo))});
      end
      mpc = ex_branch ? ex_branch_pc : s_acc ? mpc + 32'd4 : mpc;
      cyc++;
    end
    #1;
  endtask
  task automatic do_reset();
    rst_b = 0; id_pipe_ready = 0; id_pipe_flush = 0; ex_branch = 0; aprob = 100; lat_lo = 1; lat_hi = 1;
    step(); step();
    rst_b = 1;
  endtask
  task automatic test_reset();
    rst_b = 0;
    step(); step();
    total++;
    if (id_pipe_valid !== 0 || iram_req !== 0 || id_pipe_pc !== 0 || id_pipe_instruction !== 0) begin
      bad++; $display("FAIL reset_out got v=%b r=%b pc=%h ins=%h exp all 0", id_pipe_valid, iram_req, id_pipe_pc, id_pipe_instruction);
    end
    total++;
    if (iram_write !== 0 || iram_wstrb !== 0 || iram_wdata !== 0) begin
      bad++; $display("FAIL write_const got %b/%h/%h exp 0", iram_write, iram_wstrb, iram_wdata);
    end
    rst_b = 1;
    #1;
    total++;
    if (iram_req !== 1 || iram_addr !== RESET_PC) begin
      bad++; $display("FAIL first_req got req=%b addr=%h exp 1/%h", iram_req, iram_addr, RESET_PC);
    end
  endtask
  task automatic test_streaming();
    id_pipe_ready = 1;
    repeat (20) step();
    total++;
    if (got_pc.size() < 16) begin bad++; $display("FAIL stream_count got=%0d exp>=16", got_pc.size()); end
    for (int k = 0; k < got_pc.size(); k++) begin
      total++;
      if (got_pc[k] !== 32'(4 * k) || got_cyc[k] != k + 2) begin
        bad++; $display("FAIL stream[%0d] got pc=%h cyc=%0d exp pc=%h cyc=%0d", k, got_pc[k], got_cyc[k], 4 * k, k + 2);
      end
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    repeat (10) step();
    total++;
    if (dut.fifo_cnt !== 4 || iram_req !== 0) begin
      bad++; $display("FAIL bp_full got fifo=%0d req=%b exp 4/0", dut.fifo_cnt, iram_req);
    end
    id_pipe_ready = 1;
    repeat (12) step();
    total++;
    if (got_pc.size() < 8) begin bad++; $display("FAIL bp_count got=%0d exp>=8", got_pc.size()); end
    for (int k = 0; k < got_pc.size(); k++) begin
      total++;
      if (got_pc[k] !== 32'(4 * k)) begin bad++; $display("FAIL bp[%0d] got=%h exp=%h", k, got_pc[k], 4 * k); end
    end
  endtask
  task automatic test_redirect();
    do_reset();
    lat_lo = 4; lat_hi = 4;
    for (int i = 0; i < 30 && !(inflight.size() == 2 && fifoq.size() == 2); i++) step();
    total++;
    if (dut.os_cnt !== 2 || dut.fifo_cnt !== 2) begin
      bad++; $display("FAIL rd_setup got os=%0d fifo=%0d exp 2/2", dut.os_cnt, dut.fifo_cnt);
    end
    ex_branch = 1; ex_branch_pc = 32'h100;
    step();
    ex_branch = 0;
    total++;
    if (id_pipe_valid !== 0 || dut.drop_cnt !== 2) begin
      bad++; $display("FAIL rd_empty got v=%b drop=%0d exp 0/2", id_pipe_valid, dut.drop_cnt);
    end
    id_pipe_ready = 1; lat_lo = 1; lat_hi = 1;
    repeat (20) step();
    total++;
    if (got_pc.size() < 2 || got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104) begin
      bad++; $display("FAIL rd_target got n=%0d first=%h exp 100,104", got_pc.size(), got_pc.size() ? got_pc[0] : 32'hx);
    end
  endtask
  task automatic test_flush_data_ok();
    do_reset();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 30 && !(inflight.size() == 2 && pend[0].due <= cyc); i++) step();
    id_pipe_flush = 1;
    step();
    id_pipe_flush = 0;
    total++;
    if (dut.drop_cnt !== 1 || dut.os_cnt !== 1) begin
      bad++; $display("FAIL fl_drop got drop=%0d os=%0d exp 1/1", dut.drop_cnt, dut.os_cnt);
    end
    aprob = 0;
    for (int i = 0; i < 20 && pend.size() > 0; i++) step();
    total++;
    if (dut.os_cnt !== 0 || dut.drop_cnt !== 0 || id_pipe_valid !== 0) begin
      bad++; $display("FAIL fl_drain got os=%0d drop=%0d v=%b exp 0/0/0", dut.os_cnt, dut.drop_cnt, id_pipe_valid);
    end
    aprob = 100; id_pipe_ready = 1;
    repeat (10) step();
    total++;
    if (got_pc.size() < 2 || got_pc[0] !== 32'h8 || got_pc[1] !== 32'hc) begin
      bad++; $display("FAIL fl_resume got n=%0d first=%h exp 8,c", got_pc.size(), got_pc.size() ? got_pc[0] : 32'hx);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    id_pipe_ready = 1; ex_branch = 1; ex_branch_pc = 32'hFFFF_FFF8;
    step();
    ex_branch = 0;
    repeat (10) step();
    total++;
    if (got_pc.size() < 4 || got_pc[0] !== 32'hFFFF_FFF8 || got_pc[1] !== 32'hFFFF_FFFC || got_pc[2] !== 0 || got_pc[3] !== 4 || got_cyc[0] != 3) begin
      bad++; $display("FAIL wrap got n=%0d pc0=%h cyc0=%0d exp fffffff8@3", got_pc.size(), got_pc.size() ? got_pc[0] : 32'hx, got_cyc.size() ? got_cyc[0] : -1);
    end
  endtask
  task automatic test_slow_ram();
    int r;
    do_reset();
    aprob = 50; lat_lo = 1; lat_hi = 5;
    repeat (3000) begin
      r = $urandom_range(99);
      id_pipe_ready = $urandom_range(99) < 70;
      ex_branch = r < 2;
      id_pipe_flush = r >= 2 && r < 4;
      ex_branch_pc = $urandom & 32'hFFFF_FFFC;
      step();
    end
    ex_branch = 0; id_pipe_flush = 0;
    total++;
    if (got_pc.size() < 200) begin bad++; $display("FAIL slow_count got=%0d exp>=200", got_pc.size()); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    lat_lo = 5; lat_hi = 5;
    for (int i = 0; i < 20 && inflight.size() < 2; i++) step();
    total++;
    if (dut.os_cnt !== 2) begin bad++; $display("FAIL rm_setup got os=%0d exp 2", dut.os_cnt); end
    rst_b = 0;
    step();
    total++;
    if (id_pipe_valid !== 0 || iram_req !== 0 || id_pipe_pc !== 0 || id_pipe_instruction !== 0 || dut.os_cnt !== 0) begin
      bad++; $display("FAIL rm_out got v=%b r=%b pc=%h os=%0d exp 0", id_pipe_valid, iram_req, id_pipe_pc, dut.os_cnt);
    end
    rst_b = 1; lat_lo = 1; lat_hi = 1; id_pipe_ready = 1;
    #1;
    total++;
    if (iram_req !== 1 || iram_addr !== RESET_PC) begin
      bad++; $display("FAIL rm_req got req=%b addr=%h exp 1/%h", iram_req, iram_addr, RESET_PC);
    end
    repeat (10) step();
    total++;
    if (got_pc.size() < 2 || got_pc[0] !== RESET_PC || got_pc[1] !== RESET_PC + 4) begin
      bad++; $display("FAIL rm_resume got n=%0d first=%h exp %h", got_pc.size(), got_pc.size() ? got_pc[0] : 32'hx, RESET_PC);
    end
  endtask
  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_flush_data_ok();
    test_wrap();
    test_slow_ram();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
